// File: rtl/multibyte_add_seq_pkg.sv
// Shared constants for the byte-serial wide adder: slice width and FSM encodings.
package multibyte_add_seq_pkg;

  localparam int unsigned ByteW = 8;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

endpackage

// File: rtl/byte_add_cin.sv
// 8-bit ripple-carry slice with carry-in; also exposes the carry into bit 7
// so the caller can derive signed overflow.
module byte_add_cin
  import multibyte_add_seq_pkg::*;
(
  input  logic [ByteW-1:0] a_i,
  input  logic [ByteW-1:0] b_i,
  input  logic             cin_i,
  output logic [ByteW-1:0] sum_o,
  output logic             cout_o,
  output logic             c7_o
);

  logic [ByteW:0] carry;

  assign carry[0] = cin_i;

  for (genvar i = 0; i < ByteW; i++) begin : g_bit
    one_bit_adder u_fa (
      .a_i    (a_i[i]),
      .b_i    (b_i[i]),
      .cin_i  (carry[i]),
      .sum_o  (sum_o[i]),
      .cout_o (carry[i+1])
    );
  end

  assign cout_o = carry[ByteW];
  assign c7_o   = carry[ByteW-1];

endmodule

// File: rtl/one_bit_adder.sv
// Full adder cell shared with the eight_bit_adder datapath.
module one_bit_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);

  assign sum_o  = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule

// File: rtl/multibyte_add_seq.sv
// Wide add/subtract built from one byte slice, processed LSB first, one byte
// per clock, with the inter-byte carry held in a register.
module multibyte_add_seq
  import multibyte_add_seq_pkg::*;
#(
  parameter int unsigned NUM_BYTES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_i,
  input  logic                     sub_i,
  input  logic [8*NUM_BYTES-1:0]   a_i,
  input  logic [8*NUM_BYTES-1:0]   b_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [8*NUM_BYTES-1:0]   result_o,
  output logic                     carry_out_o,
  output logic                     overflow_o
);

  localparam int unsigned W    = ByteW * NUM_BYTES;
  localparam int unsigned IdxW = $clog2(NUM_BYTES);

  logic [1:0]      state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    op_a_q, op_a_d;
  logic [W-1:0]    op_b_q, op_b_d;
  logic [W-1:0]    result_q, result_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;

  logic [ByteW-1:0] slice_a, slice_b, slice_sum;
  logic             slice_cout, slice_c7;
  logic             last_byte;

  // Select the operand bytes addressed by idx.
  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int unsigned i = 0; i < NUM_BYTES; i++) begin
      if (idx_q == IdxW'(i)) begin
        slice_a = op_a_q[i*ByteW +: ByteW];
        slice_b = op_b_q[i*ByteW +: ByteW];
      end
    end
  end

  byte_add_cin u_slice (
    .a_i    (slice_a),
    .b_i    (slice_b),
    .cin_i  (carry_q),
    .sum_o  (slice_sum),
    .cout_o (slice_cout),
    .c7_o   (slice_c7)
  );

  assign last_byte = (idx_q == IdxW'(NUM_BYTES - 1));

  // FSM and datapath next-state; subtract is A + ~B + 1 via inverted B and carry-in.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          op_a_d   = a_i;
          op_b_d   = b_i ^ {W{sub_i}};
          carry_d  = sub_i;
          idx_d    = '0;
          result_d = '0;
          state_d  = StRun;
        end
      end
      StRun: begin
        for (int unsigned i = 0; i < NUM_BYTES; i++) begin
          if (idx_q == IdxW'(i)) begin
            result_d[i*ByteW +: ByteW] = slice_sum;
          end
        end
        carry_d = slice_cout;
        if (last_byte) begin
          cout_d  = slice_cout;
          ovf_d   = slice_c7 ^ slice_cout;
          state_d = StDone;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers; asynchronous reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy_o      = (state_q != StIdle);
  assign done_o      = (state_q == StDone);
  assign result_o    = result_q;
  assign carry_out_o = cout_q;
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_multibyte_add_seq.sv
`timescale 1ns/1ns
module tb_multibyte_add_seq;

  localparam int unsigned NB = 4;
  localparam int unsigned W  = 8 * NB;

  logic         clk;
  logic         rst_n;
  logic         start_i;
  logic         sub_i;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] result_o;
  logic         carry_out_o;
  logic         overflow_o;

  int n_checks = 0;
  int n_errors = 0;

  multibyte_add_seq #(.NUM_BYTES(NB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .sub_i       (sub_i),
    .a_i         (a_i),
    .b_i         (b_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .result_o    (result_o),
    .carry_out_o (carry_out_o),
    .overflow_o  (overflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic. Returns {overflow, carry_out, result}.
  function automatic logic [W+1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic s);
    logic [W:0] full;
    longint     sa, sb, sr;
    logic       cout, ovf;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!s) begin
      full = {1'b0, a} + {1'b0, b};
      cout = full[W];
      sr   = sa + sb;
    end else begin
      full = {1'b0, a - b};
      cout = (a >= b);
      sr   = sa - sb;
    end
    ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    return {ovf, cout, full[W-1:0]};
  endfunction

  // Called #1 after a clock edge with the DUT idle. Optionally fires a
  // conflicting start while the operation is running.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input bit inject);
    logic [W+1:0] exp;
    int           k;
    bit           seen;
    exp     = ref_op(a, b, s);
    a_i     = a;
    b_i     = b;
    sub_i   = s;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    check({tag, " busy_after_accept"}, 64'(busy_o), 64'd1);
    k    = 0;
    seen = 0;
    while (!seen && k < 20) begin
      if (inject && k == 1) begin
        start_i = 1'b1;
        a_i     = ~a;
        b_i     = a ^ 32'h5a5a_a5a5;
        sub_i   = ~s;
      end else begin
        start_i = 1'b0;
      end
      @(posedge clk); #1;
      k++;
      if (done_o) seen = 1;
    end
    check({tag, " latency"}, 64'(k), 64'(NB));
    check({tag, " result"}, 64'(result_o), 64'(exp[W-1:0]));
    check({tag, " carry_out"}, 64'(carry_out_o), 64'(exp[W]));
    check({tag, " overflow"}, 64'(overflow_o), 64'(exp[W+1]));
    @(posedge clk); #1;
    check({tag, " done_pulse_end"}, {62'd0, done_o, busy_o}, 64'd0);
    check({tag, " result_held"}, 64'(result_o), 64'(exp[W-1:0]));
  endtask

  initial begin
    rst_n   = 1'b0;
    start_i = 1'b0;
    sub_i   = 1'b0;
    a_i     = '0;
    b_i     = '0;
    #1;
    check("reset outputs", {busy_o, done_o, carry_out_o, overflow_o, result_o}, 64'd0);
    #20;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("add_ff_1",   32'h0000_00FF, 32'h0000_0001, 1'b0, 0);
    run_op("add_wrap",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
    run_op("add_ovf",    32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0);
    run_op("sub_5_7",    32'd5,         32'd7,         1'b1, 0);
    run_op("sub_7_5",    32'd7,         32'd5,         1'b1, 0);
    run_op("sub_ovf",    32'h8000_0000, 32'h0000_0001, 1'b1, 0);
    run_op("ignore_start", 32'h1234_5678, 32'h0FED_CBA9, 1'b0, 1);

    // Reset mid-run: outputs must clear without waiting for a clock edge.
    a_i     = 32'hFFFF_FFFF;
    b_i     = 32'hFFFF_FFFF;
    sub_i   = 1'b0;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_run_reset outputs", {busy_o, done_o, carry_out_o, overflow_o, result_o}, 64'd0);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset idle", {62'd0, busy_o, done_o}, 64'd0);
    run_op("after_reset", 32'h8000_0001, 32'h8000_0001, 1'b0, 0);

    for (int i = 0; i < 200; i++) begin
      run_op($sformatf("rand%0d", i), 32'($urandom), 32'($urandom),
             1'($urandom_range(0, 1)), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
